// File: rtl/apb3_slave_mem.sv
// APB3 slave backed by a DEPTH x 32-bit register memory with a sticky protocol-violation flag.
// Latency: setup cycle plus WAIT_CYCLES+1 enable cycles; pready, pslverr and prdata come from flops.
// Backpressure: holds pready low for WAIT_CYCLES enable cycles; a dropped psel aborts the transfer.
module apb3_slave_mem #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        prot_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          write_q;
    logic          pready_q;
    logic          pslverr_q;
    logic [31:0]   prdata_q;
    logic          prot_err_q;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   dec_addr;
    logic          dec_write;
    logic          dec_err;
    logic [AW-1:0] dec_idx;
    logic [31:0]   rsp_rdata;
    logic          bus_changed;
    logic          mem_we;

    // Decode the address the transfer will use: live inputs during setup, the latched copy afterwards
    always_comb begin
        dec_addr  = (state_q == IDLE) ? paddr  : addr_q;
        dec_write = (state_q == IDLE) ? pwrite : write_q;
        dec_err   = (dec_addr[1:0] != 2'b00) || (dec_addr[31:AW+2] != '0);
        dec_idx   = dec_addr[AW+1:2];
        rsp_rdata = (!dec_write && !dec_err) ? mem_q[dec_idx] : 32'h0;
    end

    // Setup-phase values must stay stable while the transfer is in progress
    assign bus_changed = psel && ((paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q));

    // Memory is only written at the completing edge of a valid, non-aborted write
    assign mem_we = (state_q == DONE) && psel && write_q && !dec_err;

    // Transfer FSM with registered response outputs and the sticky violation flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            write_q    <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= 32'h0;
            prot_err_q <= 1'b0;
        end else begin
            // Response outputs are only ever high for the single DONE cycle
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
            case (state_q)
                IDLE: begin
                    if (penable) begin
                        prot_err_q <= 1'b1;
                    end else if (psel) begin
                        addr_q  <= paddr;
                        wdata_q <= pwdata;
                        write_q <= pwrite;
                        // The setup cycle is the first step of the count, so with no
                        // wait states the first enable cycle already carries pready
                        if (WAIT_LD == 4'd0) begin
                            cnt_q     <= 4'd0;
                            state_q   <= DONE;
                            pready_q  <= 1'b1;
                            pslverr_q <= dec_err;
                            prdata_q  <= rsp_rdata;
                        end else begin
                            cnt_q   <= WAIT_LD;
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q    <= IDLE;
                        cnt_q      <= 4'd0;
                        prot_err_q <= 1'b1;
                    end else begin
                        if (bus_changed) begin
                            prot_err_q <= 1'b1;
                        end
                        if (penable) begin
                            if (cnt_q > 4'd1) begin
                                cnt_q <= cnt_q - 4'd1;
                            end else begin
                                cnt_q     <= 4'd0;
                                state_q   <= DONE;
                                pready_q  <= 1'b1;
                                pslverr_q <= dec_err;
                                prdata_q  <= rsp_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (!psel || bus_changed) begin
                        prot_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Word storage, returned to INIT_VALUE by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_VALUE;
            end
        end else if (mem_we) begin
            mem_q[dec_idx] <= wdata_q;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign prot_err = prot_err_q;

endmodule
